div_ctrl: RTL and testbench



---
 rtl/common.sv | 22 ++
 rtl/div_ctrl.sv | 108 ++++++++++
 tb/tb_div_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// Shared execute-stage types and constants.
// Divider op encodings are used by both div_ctrl and the divider decode.
package common;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } div_ctrl_state_t;

    localparam logic [2:0] DIV_T_DIVW  = 3'b000;
    localparam logic [2:0] DIV_T_DIVUW = 3'b001;
    localparam logic [2:0] DIV_T_REMW  = 3'b010;
    localparam logic [2:0] DIV_T_REMUW = 3'b011;
    localparam logic [2:0] DIV_T_DIV   = 3'b100;
    localparam logic [2:0] DIV_T_DIVU  = 3'b101;
    localparam logic [2:0] DIV_T_REM   = 3'b110;
    localparam logic [2:0] DIV_T_REMU  = 3'b111;

endpackage

// File: rtl/div_ctrl.sv
// Sequencing controller for the multi-cycle divider.
// One op in flight; flushes drain the divider and discard the result.
module div_ctrl
    import common::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [2:0]       req_type,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dbz,
    output logic             div_start,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    output logic [2:0]       div_type,
    input  logic [XLEN-1:0]  div_result,
    input  logic             div_done,
    input  logic             div_busy,
    input  logic             div_by_zero,
    output logic             busy,
    output logic [31:0]      perf_div_cycles
);

    div_ctrl_state_t  state;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [2:0]       op_type;
    logic [TAG_W-1:0] op_tag;

    assign req_ready    = (state == IDLE) && !flush && !reset;
    // Hold off while the previous op's done tail is still visible
    assign div_start    = (state == ISSUE) && !div_busy && !div_done && !flush;
    assign rsp_valid    = (state == RESP);
    assign busy         = (state != IDLE);
    assign div_dividend = op_a;
    assign div_divisor  = op_b;
    assign div_type     = op_type;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            op_a            <= '0;
            op_b            <= '0;
            op_type         <= '0;
            op_tag          <= '0;
            rsp_data        <= '0;
            rsp_tag         <= '0;
            rsp_dbz         <= 1'b0;
            perf_div_cycles <= '0;
        end else begin
            if (state != IDLE && perf_div_cycles != 32'hFFFF_FFFF)
                perf_div_cycles <= perf_div_cycles + 32'd1;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_a    <= req_a;
                        op_b    <= req_b;
                        op_type <= req_type;
                        op_tag  <= req_tag;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush)
                        state <= IDLE;
                    else if (div_start)
                        state <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        if (!flush) begin
                            rsp_data <= div_result;
                            rsp_tag  <= op_tag;
                            rsp_dbz  <= div_by_zero;
                            state    <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                RESP: begin
                    if (flush || rsp_ready)
                        state <= IDLE;
                end
                DRAIN: begin
                    // No abort on the divider: let it finish, drop the result
                    if (div_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider beside it.
// Divider: 66-cycle 64-bit ops, 34-cycle W ops, 1 cycle for dbz/overflow, done held 2 cycles.
module tb_div_ctrl;
    import common::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [2:0]  req_type = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        rsp_dbz;
    logic        div_start;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic [2:0]  div_type;
    logic [63:0] div_result;
    logic        div_done;
    logic        div_busy;
    logic        div_by_zero;
    logic        busy;
    logic [31:0] perf_div_cycles;

    logic        done_raw;
    logic        xdone = 1'b0;
    logic        tail;
    logic [7:0]  cnt;
    logic [72:0] mo;

    int n_vec = 0;
    int n_err = 0;

    assign div_done = done_raw | xdone;

    div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_type(req_type), .req_tag(req_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz),
        .div_start(div_start), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_type(div_type),
        .div_result(div_result), .div_done(div_done),
        .div_busy(div_busy), .div_by_zero(div_by_zero),
        .busy(busy), .perf_div_cycles(perf_div_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [72:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] ty);
        logic w, sgn, rm, zero, ovf;
        logic [63:0] x, y, q, r, res;
        logic [7:0] lat;
        w   = !ty[2];
        sgn = !ty[0];
        rm  = ty[1];
        if (w) begin
            x = sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
            y = sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
        end else begin
            x = a;
            y = b;
        end
        zero = (y == 64'd0);
        ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero) begin
            q = '1;
            r = x;
        end else if (ovf) begin
            q = x;
            r = '0;
        end else if (sgn) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        res = rm ? r : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        lat = (zero || ovf) ? 8'd1 : (w ? 8'd34 : 8'd66);
        return {lat, zero, res};
    endfunction

    assign mo = model(div_dividend, div_divisor, div_type);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0; tail <= 1'b0; done_raw <= 1'b0;
            div_busy <= 1'b0; div_result <= '0; div_by_zero <= 1'b0;
        end else if (div_start) begin
            div_result  <= mo[63:0];
            div_by_zero <= mo[64];
            if (mo[72:65] == 8'd1) begin
                done_raw <= 1'b1; tail <= 1'b1; cnt <= '0; div_busy <= 1'b0;
            end else begin
                cnt <= mo[72:65] - 8'd1; div_busy <= 1'b1; done_raw <= 1'b0;
            end
        end else if (cnt > 8'd1) begin
            cnt <= cnt - 8'd1;
        end else if (cnt == 8'd1) begin
            cnt <= '0; div_busy <= 1'b0; done_raw <= 1'b1; tail <= 1'b1;
        end else if (tail) begin
            tail <= 1'b0;
        end else begin
            done_raw <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] ty, input logic [4:0] tag);
        req_a = a; req_b = b; req_type = ty; req_tag = tag; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int n, output int idle);
        n = 0;
        idle = 0;
        while (!rsp_valid && n < limit) begin
            if (!busy) idle++;
            tick();
            n++;
        end
        if (!busy) idle++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idle, bad, k;
        logic [31:0] exp_perf;
        exp_perf = 32'd0;

        #1 reset = 1'b1;
        repeat (2) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_perf", perf_div_cycles, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        #1 chk("req_ready_idle", req_ready, 1);
        flush = 1'b1;
        #1 chk("flush_blocks_ready", req_ready, 0);
        flush = 1'b0;

        // DIV 100/7
        send(64'd100, 64'd7, DIV_T_DIV, 5'd3);
        chk("t1_start", div_start, 1);
        chk("t1_dividend", div_dividend, 100);
        chk("t1_type", div_type, DIV_T_DIV);
        wait_rsp(200, n, idle);
        chk("t1_latency", 1 + n, 68);
        chk("t1_busy_gaps", idle, 0);
        chk("t1_data", rsp_data, 14);
        chk("t1_tag", rsp_tag, 3);
        chk("t1_dbz", rsp_dbz, 0);
        tick();
        chk("t1_busy_clear", busy, 0);
        exp_perf += 32'd68;
        chk("t1_perf", perf_div_cycles, exp_perf);

        // REMW -7 % 2
        send(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV_T_REMW, 5'd2);
        wait_rsp(200, n, idle);
        chk("t2_latency", 1 + n, 36);
        chk("t2_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_tag", rsp_tag, 2);
        tick();
        exp_perf += 32'd36;

        // DIVU by zero, then back-to-back REM behind an extended done tail
        req_a = 64'd5; req_b = 64'd0; req_type = DIV_T_DIVU; req_tag = 5'd7;
        req_valid = 1'b1;
        chk("t3_ready_c0", req_ready, 1);
        tick();
        chk("t3_start_c1", div_start, 1);
        chk("t3_ready_c1", req_ready, 0);
        req_a = 64'd100; req_b = 64'd7; req_type = DIV_T_REM; req_tag = 5'd9;
        tick();
        chk("t3_ready_c2", req_ready, 0);
        chk("t3_rsp_c2", rsp_valid, 0);
        tick();
        chk("t3_rsp_c3", rsp_valid, 1);
        chk("t3_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_dbz", rsp_dbz, 1);
        chk("t3_tag", rsp_tag, 7);
        chk("t3_ready_c3", req_ready, 0);
        xdone = 1'b1;
        tick();
        chk("t3_ready_c4", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t3_busy_c5", busy, 1);
        chk("t3_nostart_c5", div_start, 0);
        chk("t3_op2_a", div_dividend, 100);
        tick();
        chk("t3_nostart_c6", div_start, 0);
        xdone = 1'b0;
        #1 chk("t3_start_c6", div_start, 1);
        wait_rsp(200, n, idle);
        chk("t3_op2_latency", n, 67);
        chk("t3_op2_data", rsp_data, 2);
        chk("t3_op2_tag", rsp_tag, 9);
        chk("t3_op2_dbz", rsp_dbz, 0);
        tick();
        exp_perf += 32'd72;

        // Flush in WAIT at cycle 20 -> drain
        send(64'd1000, 64'd10, DIV_T_DIV, 5'd4);
        repeat (19) tick();
        chk("t4_state_wait", dut.state, WAIT);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_state_drain", dut.state, DRAIN);
        bad = 0;
        k = 21;
        while (busy && k < 200) begin
            if (rsp_valid || req_ready) bad++;
            tick();
            k++;
        end
        chk("t4_drain_quiet", bad, 0);
        chk("t4_idle_cycle", k, 68);
        chk("t4_ready_after", req_ready, 1);
        exp_perf += 32'd67;
        send(64'd1000, 64'd10, DIV_T_DIVU, 5'd5);
        wait_rsp(200, n, idle);
        chk("t4_next_latency", 1 + n, 68);
        chk("t4_next_data", rsp_data, 100);
        chk("t4_next_tag", rsp_tag, 5);
        tick();
        exp_perf += 32'd68;

        // Backpressure in RESP, then flush drops it
        rsp_ready = 1'b0;
        send(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, DIV_T_DIVW, 5'd11);
        wait_rsp(200, n, idle);
        chk("t5_latency", 1 + n, 36);
        bad = 0;
        repeat (10) begin
            tick();
            if (!rsp_valid || rsp_data !== 64'hFFFF_FFFF_FFFF_FFF2 || rsp_tag !== 5'd11) bad++;
        end
        chk("t5_stable", bad, 0);
        chk("t5_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFF2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_dropped", rsp_valid, 0);
        chk("t5_idle", busy, 0);
        exp_perf += 32'd46;
        chk("t5_perf", perf_div_cycles, exp_perf);
        rsp_ready = 1'b1;

        // Reset in cycle 30 of an op
        send(64'd7, 64'd7, DIV_T_DIV, 5'd1);
        repeat (29) tick();
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_state", dut.state, IDLE);
        chk("t6_ready", req_ready, 0);
        chk("t6_perf", perf_div_cycles, 0);
        chk("t6_dividend", div_dividend, 0);
        chk("t6_rsp_data", rsp_data, 0);
        chk("t6_rsp_tag", rsp_tag, 0);
        chk("t6_start", div_start, 0);
        tick();
        reset = 1'b0;
        #1 chk("t6_ready_after", req_ready, 1);
        send(64'd7, 64'd7, DIV_T_DIV, 5'd1);
        wait_rsp(200, n, idle);
        chk("t6_latency", 1 + n, 68);
        chk("t6_data", rsp_data, 1);
        chk("t6_tag", rsp_tag, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
